// File: rtl/nand_target_emu_pkg.sv
// Shared types and constants for the NAND target emulator: FSM states, opcodes,
// read-data sources and status register layout.
package nand_target_emu_pkg;

    typedef enum logic [2:0] {
        IDLE, ADDR, DIN, CONFIRM, DOUT, BUSY_RD, BUSY_PG, BUSY_RST
    } state_t;

    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_PROG, OP_ID} op_t;

    typedef enum logic [1:0] {SRC_BUF, SRC_ID, SRC_STATUS} src_t;

    localparam logic [7:0] CMD_READ      = 8'h00;
    localparam logic [7:0] CMD_READ_CONF = 8'h30;
    localparam logic [7:0] CMD_PROG      = 8'h80;
    localparam logic [7:0] CMD_PROG_CONF = 8'h10;
    localparam logic [7:0] CMD_READ_ID   = 8'h90;
    localparam logic [7:0] CMD_STATUS    = 8'h70;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    localparam int unsigned SB_WP_N = 7;
    localparam int unsigned SB_RDY  = 6;
    localparam int unsigned SB_ARDY = 5;
    localparam int unsigned SB_FAIL = 0;

    function automatic logic [7:0] status_byte(input logic wp_n, input logic rdy, input logic fail);
        logic [7:0] s;
        s          = '0;
        s[SB_WP_N] = wp_n;
        s[SB_RDY]  = rdy;
        s[SB_ARDY] = rdy;
        s[SB_FAIL] = fail;
        return s;
    endfunction

endpackage

// File: rtl/nand_emu_array.sv
// Emulated flash array: single-port, 16 bits wide, one read or write per cycle.
// Read data is registered (read-before-write), contents are not reset.
module nand_emu_array #(
    parameter int unsigned PAGE_BYTES = 64,
    parameter int unsigned NUM_PAGES  = 16,
    localparam int unsigned AW        = $clog2(NUM_PAGES * PAGE_BYTES / 2)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [NUM_PAGES * PAGE_BYTES / 2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nand_target_emu.sv
// NAND target emulator: decodes CLE/ALE/W-R# pin cycles, keeps a page buffer,
// emulates busy timing for read/program/reset and returns DDR read data with DQS.
module nand_target_emu
    import nand_target_emu_pkg::*;
#(
    parameter int unsigned DQ_WIDTH    = 8,
    parameter int unsigned PAGE_BYTES  = 64,
    parameter int unsigned NUM_PAGES   = 16,
    parameter int unsigned ADDR_CYCLES = 5,
    parameter int unsigned T_R         = 64,
    parameter int unsigned T_PROG      = 96,
    parameter int unsigned T_RST       = 16,
    parameter logic [31:0] ID_WORD     = 32'h9551_D32C
) (
    input  logic                v_clk0,
    input  logic                v_rstn0,
    input  logic                nand_clk_en,
    input  logic                cen,
    input  logic                cle,
    input  logic                ale,
    input  logic                wrn,
    input  logic                wpn,
    input  logic [DQ_WIDTH-1:0] dq_in_rise,
    input  logic [DQ_WIDTH-1:0] dq_in_fall,
    output logic [DQ_WIDTH-1:0] dq_out_rise,
    output logic [DQ_WIDTH-1:0] dq_out_fall,
    output logic                dq_oe_n,
    output logic                dqs_oe_n,
    output logic                rb_n,
    output logic                err_cmd
);

    localparam int unsigned COL_W = $clog2(PAGE_BYTES);
    localparam int unsigned WRD_W = COL_W - 1;
    localparam int unsigned PG_W  = $clog2(NUM_PAGES);
    localparam int unsigned AC_W  = $clog2(ADDR_CYCLES + 1);
    localparam int unsigned T_MAX = (T_R > T_PROG) ? ((T_R > T_RST) ? T_R : T_RST)
                                                   : ((T_PROG > T_RST) ? T_PROG : T_RST);
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam logic [WRD_W:0] CP_END = (WRD_W + 1)'(PAGE_BYTES / 2);

    state_t            state_q, state_d;
    op_t               op_q;
    src_t              src_q;
    logic [AC_W-1:0]   addr_cnt_q, addr_last;
    logic [COL_W-1:0]  col_q;
    logic [PG_W-1:0]   page_q;
    logic [1:0]        id_idx_q;
    logic [CNT_W-1:0]  busy_cnt_q;
    logic [WRD_W:0]    cp_cnt_q;
    logic              fail_q, prog_en_q, err_q, err_d, oe_q;
    logic [7:0]        dq_rise_q, dq_fall_q;
    logic [7:0]        pbuf [PAGE_BYTES];
    logic [31:0]       id_word;

    logic valid, is_cmd, is_addr, is_data, is_busy;
    logic addr_we, din_we, dout_we, cp_we;
    logic cmd_rst, cmd_status, cmd_id, cmd_read, cmd_prog, conf_rd, conf_pg;
    logic [WRD_W-1:0] cp_word, arr_word;
    logic             arr_we;
    logic [15:0]      arr_wdata, arr_rdata;

    assign id_word   = ID_WORD;
    assign valid     = nand_clk_en & ~cen;
    assign is_cmd    = valid & cle & ~ale;
    assign is_addr   = valid & ~cle & ale;
    assign is_data   = valid & cle & ale;
    assign is_busy   = state_q inside {BUSY_RD, BUSY_PG, BUSY_RST};
    assign addr_we   = is_addr & (state_q == ADDR);
    assign din_we    = is_data & wrn & (state_q == DIN);
    assign dout_we   = is_data & ~wrn;
    assign addr_last = (op_q == OP_ID) ? '0 : AC_W'(ADDR_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        cmd_rst    = 1'b0;
        cmd_status = 1'b0;
        cmd_id     = 1'b0;
        cmd_read   = 1'b0;
        cmd_prog   = 1'b0;
        conf_rd    = 1'b0;
        conf_pg    = 1'b0;
        if (is_busy) begin
            if (busy_cnt_q == '0) state_d = IDLE;
        end else if (cen) begin
            state_d = IDLE;
        end
        if (is_cmd) begin
            if (dq_in_rise == CMD_RESET) begin
                cmd_rst = 1'b1;
                state_d = BUSY_RST;
            end else if (dq_in_rise == CMD_STATUS) begin
                cmd_status = 1'b1;
                if (!is_busy) state_d = IDLE;
            end else if (is_busy) begin
                err_d = 1'b1;
            end else begin
                case (dq_in_rise)
                    CMD_READ_ID: begin cmd_id   = 1'b1; state_d = ADDR; end
                    CMD_READ:    begin cmd_read = 1'b1; state_d = ADDR; end
                    CMD_PROG:    begin cmd_prog = 1'b1; state_d = ADDR; end
                    CMD_READ_CONF: begin
                        if (state_q == CONFIRM && op_q == OP_READ) begin
                            conf_rd = 1'b1;
                            state_d = BUSY_RD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_PROG_CONF: begin
                        if (state_q == DIN) begin
                            conf_pg = 1'b1;
                            state_d = BUSY_PG;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else if (addr_we && addr_cnt_q == addr_last) begin
            case (op_q)
                OP_READ: state_d = CONFIRM;
                OP_PROG: state_d = DIN;
                default: state_d = IDLE;
            endcase
        end else if (dout_we && (state_q inside {IDLE, DIN, DOUT})) begin
            state_d = DOUT;
        end
    end

    // Array reads run one word ahead of the buffer fill: word 0 is fetched in the
    // confirm cycle so the copy fits exactly PAGE_BYTES/2 busy cycles.
    assign cp_word   = WRD_W'(cp_cnt_q);
    assign cp_we     = (state_q == BUSY_RD) && (cp_cnt_q != CP_END);
    assign arr_we    = (state_q == BUSY_PG) && prog_en_q && (cp_cnt_q != CP_END);
    assign arr_word  = (state_q == BUSY_RD) ? WRD_W'(cp_cnt_q + 1'b1)
                     : (state_q == BUSY_PG) ? cp_word : '0;
    assign arr_wdata = {pbuf[{cp_word, 1'b1}], pbuf[{cp_word, 1'b0}]};

    nand_emu_array #(
        .PAGE_BYTES (PAGE_BYTES),
        .NUM_PAGES  (NUM_PAGES)
    ) u_array (
        .clk   (v_clk0),
        .we    (arr_we),
        .addr  ({page_q, arr_word}),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge v_clk0) begin
        if (din_we) begin
            pbuf[col_q]                <= dq_in_rise;
            pbuf[col_q + COL_W'(1)]    <= dq_in_fall;
        end else if (cp_we) begin
            pbuf[{cp_word, 1'b0}]      <= arr_rdata[7:0];
            pbuf[{cp_word, 1'b1}]      <= arr_rdata[15:8];
        end
    end

    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            state_q    <= IDLE;
            op_q       <= OP_NONE;
            src_q      <= SRC_STATUS;
            addr_cnt_q <= '0;
            col_q      <= '0;
            page_q     <= '0;
            id_idx_q   <= '0;
            busy_cnt_q <= '0;
            cp_cnt_q   <= '0;
            fail_q     <= 1'b0;
            prog_en_q  <= 1'b0;
            err_q      <= 1'b0;
            oe_q       <= 1'b1;
            dq_rise_q  <= '0;
            dq_fall_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;

            if (cmd_id | cmd_read | cmd_prog) addr_cnt_q <= '0;
            else if (addr_we)                 addr_cnt_q <= addr_cnt_q + AC_W'(1);

            if (cmd_id)        op_q <= OP_ID;
            else if (cmd_read) op_q <= OP_READ;
            else if (cmd_prog) op_q <= OP_PROG;

            if (cmd_status)                src_q <= SRC_STATUS;
            else if (cmd_id)               src_q <= SRC_ID;
            else if (cmd_read | cmd_prog)  src_q <= SRC_BUF;

            if (cmd_id || (addr_we && op_q == OP_ID))  id_idx_q <= '0;
            else if (dout_we && src_q == SRC_ID)       id_idx_q <= id_idx_q + 2'd2;

            if (addr_we && op_q != OP_ID && addr_cnt_q == AC_W'(0))
                col_q <= COL_W'(dq_in_rise);
            else if (addr_we && op_q != OP_ID && addr_cnt_q == AC_W'(1))
                col_q <= COL_W'({dq_in_rise, 8'(col_q)});
            else if (din_we || (dout_we && src_q == SRC_BUF))
                col_q <= col_q + COL_W'(2);

            if (addr_we && op_q != OP_ID && addr_cnt_q == AC_W'(2))
                page_q <= PG_W'(dq_in_rise);

            if (conf_rd)                           busy_cnt_q <= CNT_W'(T_R - 1);
            else if (conf_pg)                      busy_cnt_q <= CNT_W'(T_PROG - 1);
            else if (cmd_rst)                      busy_cnt_q <= CNT_W'(T_RST - 1);
            else if (is_busy && busy_cnt_q != '0)  busy_cnt_q <= busy_cnt_q - CNT_W'(1);

            if (conf_rd | conf_pg)                 cp_cnt_q <= '0;
            else if (cp_we || (state_q == BUSY_PG && cp_cnt_q != CP_END))
                cp_cnt_q <= cp_cnt_q + 1'b1;

            if (cmd_prog | cmd_rst) fail_q <= 1'b0;
            else if (conf_pg)       fail_q <= ~wpn;
            if (conf_pg)            prog_en_q <= wpn;

            oe_q <= ~dout_we;
            if (dout_we) begin
                case (src_q)
                    SRC_BUF: begin
                        dq_rise_q <= pbuf[col_q];
                        dq_fall_q <= pbuf[col_q + COL_W'(1)];
                    end
                    SRC_ID: begin
                        dq_rise_q <= id_word[{id_idx_q, 3'b000} +: 8];
                        dq_fall_q <= id_word[{id_idx_q + 2'd1, 3'b000} +: 8];
                    end
                    default: begin
                        dq_rise_q <= status_byte(wpn, ~is_busy, fail_q);
                        dq_fall_q <= status_byte(wpn, ~is_busy, fail_q);
                    end
                endcase
            end
        end
    end

    assign rb_n        = ~is_busy;
    assign err_cmd     = err_q;
    assign dq_out_rise = dq_rise_q;
    assign dq_out_fall = dq_fall_q;
    assign dq_oe_n     = oe_q | cen;
    assign dqs_oe_n    = oe_q | cen;

endmodule

// File: tb/tb_nand_target_emu.sv
// Directed self-checking bench for nand_target_emu: status, ID, program/read,
// write protect, busy-time command handling, chip-enable abort and async reset.
module tb_nand_target_emu;

    logic       v_clk0 = 1'b0;
    logic       v_rstn0, nand_clk_en, cen, cle, ale, wrn, wpn;
    logic [7:0] dq_in_rise, dq_in_fall, dq_out_rise, dq_out_fall;
    logic       dq_oe_n, dqs_oe_n, rb_n, err_cmd;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 v_clk0 = ~v_clk0;

    nand_target_emu #(
        .DQ_WIDTH    (8),
        .PAGE_BYTES  (64),
        .NUM_PAGES   (16),
        .ADDR_CYCLES (5),
        .T_R         (64),
        .T_PROG      (96),
        .T_RST       (16),
        .ID_WORD     (32'hA1B2_C3D4)
    ) dut (
        .v_clk0      (v_clk0),
        .v_rstn0     (v_rstn0),
        .nand_clk_en (nand_clk_en),
        .cen         (cen),
        .cle         (cle),
        .ale         (ale),
        .wrn         (wrn),
        .wpn         (wpn),
        .dq_in_rise  (dq_in_rise),
        .dq_in_fall  (dq_in_fall),
        .dq_out_rise (dq_out_rise),
        .dq_out_fall (dq_out_fall),
        .dq_oe_n     (dq_oe_n),
        .dqs_oe_n    (dqs_oe_n),
        .rb_n        (rb_n),
        .err_cmd     (err_cmd)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic a, input logic w,
                       input logic [7:0] r, input logic [7:0] f);
        cle = c; ale = a; wrn = w; dq_in_rise = r; dq_in_fall = f;
        @(posedge v_clk0);
        #1;
    endtask

    task automatic cmd(input logic [7:0] b);                 cyc(1'b1, 1'b0, 1'b1, b, 8'h00); endtask
    task automatic adr(input logic [7:0] b);                 cyc(1'b0, 1'b1, 1'b1, b, 8'h00); endtask
    task automatic din(input logic [7:0] r, input logic [7:0] f); cyc(1'b1, 1'b1, 1'b1, r, f); endtask
    task automatic dout();                                   cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00); endtask
    task automatic idle();                                   cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00); endtask

    task automatic page_addr(input logic [7:0] page);
        adr(8'h00); adr(8'h00); adr(page); adr(8'h00); adr(8'h00);
    endtask

    task automatic wait_ready(input string tag, input int unsigned exp);
        int unsigned n = 0;
        while (rb_n === 1'b0 && n < 2000) begin
            idle();
            n++;
        end
        n_assert++;
        assert (n == exp) else begin
            n_fail++;
            $error("FAIL %s: busy for %0d cycles, expected %0d", tag, n, exp);
        end
    endtask

    // Byte j of the page is base+j, or base everywhere when solid is set.
    task automatic program_page(input logic [7:0] page, input logic [7:0] base, input bit solid);
        cmd(8'h80);
        page_addr(page);
        for (int i = 0; i < 32; i++) begin
            if (solid) din(base, base);
            else       din(base + 8'(2 * i), base + 8'(2 * i + 1));
        end
        cmd(8'h10);
        check("prog_busy_start", {7'd0, rb_n}, 8'h00);
    endtask

    task automatic read_page(input logic [7:0] page);
        cmd(8'h00);
        page_addr(page);
        cmd(8'h30);
        check("read_busy_start", {7'd0, rb_n}, 8'h00);
        wait_ready("read_busy_len", 64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        v_rstn0 = 1'b0; nand_clk_en = 1'b1; cen = 1'b1; wpn = 1'b1;
        cle = 1'b0; ale = 1'b0; wrn = 1'b1; dq_in_rise = '0; dq_in_fall = '0;
        repeat (3) @(posedge v_clk0);
        #1;
        check("rst_dq_rise", dq_out_rise, 8'h00);
        check("rst_dq_fall", dq_out_fall, 8'h00);
        check("rst_dq_oe_n", {7'd0, dq_oe_n}, 8'h01);
        check("rst_dqs_oe_n", {7'd0, dqs_oe_n}, 8'h01);
        check("rst_rb_n", {7'd0, rb_n}, 8'h01);
        check("rst_err", {7'd0, err_cmd}, 8'h00);
        v_rstn0 = 1'b1;
        cen = 1'b0;
        idle();

        // 1: status after reset
        cmd(8'h70);
        dout();
        check("stat_rise", dq_out_rise, 8'hE0);
        check("stat_fall", dq_out_fall, 8'hE0);
        check("stat_oe", {7'd0, dq_oe_n}, 8'h00);
        check("stat_dqs_oe", {7'd0, dqs_oe_n}, 8'h00);
        idle();
        check("stat_oe_off", {7'd0, dq_oe_n}, 8'h01);

        // 2: read ID wraps every four bytes
        cmd(8'h90);
        adr(8'h00);
        dout(); check("id0", dq_out_rise, 8'hD4); check("id1", dq_out_fall, 8'hC3);
        dout(); check("id2", dq_out_rise, 8'hB2); check("id3", dq_out_fall, 8'hA1);
        dout(); check("id0_wrap", dq_out_rise, 8'hD4); check("id1_wrap", dq_out_fall, 8'hC3);
        idle();

        // 3: program page 3 with 00..3F, read back with column wrap
        program_page(8'h03, 8'h00, 1'b0);
        wait_ready("prog_busy_len", 96);
        read_page(8'h03);
        for (int i = 0; i < 33; i++) begin
            dout();
            check("p3_rise", dq_out_rise, 8'((2 * i) % 64));
            check("p3_fall", dq_out_fall, 8'((2 * i + 1) % 64));
        end
        idle();

        // 4: write protect blocks the array write and sets FAIL
        program_page(8'h05, 8'h80, 1'b0);
        wait_ready("p5_busy_len", 96);
        wpn = 1'b0;
        program_page(8'h05, 8'hAA, 1'b1);
        wait_ready("wp_busy_len", 96);
        cmd(8'h70);
        dout();
        check("wp_stat_rise", dq_out_rise, 8'h61);
        check("wp_stat_fall", dq_out_fall, 8'h61);
        idle();
        wpn = 1'b1;
        read_page(8'h05);
        for (int i = 0; i < 32; i++) begin
            dout();
            check("p5_rise", dq_out_rise, 8'h80 + 8'(2 * i));
            check("p5_fall", dq_out_fall, 8'h81 + 8'(2 * i));
        end
        idle();

        // 5: commands during busy, status while busy, reset abort
        program_page(8'h03, 8'h00, 1'b0);
        cmd(8'h00);
        check("busy_err_pulse", {7'd0, err_cmd}, 8'h01);
        idle();
        check("busy_err_clear", {7'd0, err_cmd}, 8'h00);
        cmd(8'h70);
        dout();
        check("busy_stat", dq_out_rise, 8'h80);
        check("busy_stat_fall", dq_out_fall, 8'h80);
        cmd(8'hFF);
        check("rst_busy_start", {7'd0, rb_n}, 8'h00);
        wait_ready("rst_busy_len", 16);
        cmd(8'h70);
        dout();
        check("post_rst_stat", dq_out_rise, 8'hE0);
        idle();

        // 6: unsupported opcode, chip-enable abort of an address sequence
        cmd(8'hEE);
        check("bad_op_err", {7'd0, err_cmd}, 8'h01);
        cmd(8'h70);
        dout();
        cen = 1'b1;
        #1;
        check("cen_forces_oe", {7'd0, dq_oe_n}, 8'h01);
        check("cen_forces_dqs", {7'd0, dqs_oe_n}, 8'h01);
        cen = 1'b0;
        idle();
        cmd(8'h00);
        adr(8'h00);
        adr(8'h00);
        cen = 1'b1;
        idle();
        cen = 1'b0;
        adr(8'h03); adr(8'h00); adr(8'h00);
        cmd(8'h30);
        check("abort_confirm_err", {7'd0, err_cmd}, 8'h01);
        check("abort_no_busy", {7'd0, rb_n}, 8'h01);
        cmd(8'h70);
        dout();
        check("abort_stat", dq_out_rise, 8'hE0);

        // async reset part-way through programming page 3 with FF
        program_page(8'h03, 8'hFF, 1'b1);
        repeat (4) idle();
        #2;
        v_rstn0 = 1'b0;
        #1;
        check("arst_rb_n", {7'd0, rb_n}, 8'h01);
        check("arst_oe", {7'd0, dq_oe_n}, 8'h01);
        check("arst_dq", dq_out_rise, 8'h00);
        @(posedge v_clk0);
        #1;
        v_rstn0 = 1'b1;
        idle();
        read_page(8'h03);
        for (int i = 0; i < 32; i++) begin
            dout();
            if (i == 0) begin
                check("arst_written", dq_out_rise, 8'hFF);
            end else if (i >= 16) begin
                check("arst_kept_rise", dq_out_rise, 8'(2 * i));
                check("arst_kept_fall", dq_out_fall, 8'(2 * i + 1));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
